// File: rtl/stream_encryptor.sv
// Byte-stream additive cipher: out = in + key[kidx] mod 256, one output register stage.
// Optional ENCRYPTOR_DEFAULT_KEY_EN resets the key to "KEY" repeated instead of zeros.
module stream_encryptor #(
  parameter int MSG_LEN = 20,
  parameter int SEC_LEN = 3,
  localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1,
  localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_we,
  input  logic [KW-1:0] key_idx,
  input  logic [7:0]    key_byte,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  state_t          state_nx;
  logic [7:0]      key [SEC_LEN];
  logic [PW-1:0]   pos;
  logic [KW-1:0]   kidx;
  logic            accept;
  logic            last_pos;
  logic            kidx_end;
  logic            key_wr;

`ifdef ENCRYPTOR_DEFAULT_KEY_EN
  localparam logic [23:0] KEY_STR = "KEY";
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_pos = (pos == PW'(MSG_LEN - 1));
  assign kidx_end = (kidx == KW'(SEC_LEN - 1));

  // Key is frozen during a message and while a byte is being taken.
  assign key_wr = key_we && (state == IDLE) && !accept &&
                  (32'(key_idx) < SEC_LEN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && !last_pos) state_nx = RUN;
      RUN:  if (accept && last_pos)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEC_LEN; i++) begin
`ifdef ENCRYPTOR_DEFAULT_KEY_EN
        key[i] <= KEY_STR[8*(2-(i%3)) +: 8];
`else
        key[i] <= 8'h00;
`endif
      end
    end else if (key_wr) begin
      key[key_idx] <= key_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      pos       <= '0;
      kidx      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data + key[kidx];
      out_last  <= last_pos;
      pos       <= last_pos ? '0 : pos + 1'b1;
      kidx      <= (last_pos || kidx_end) ? '0 : kidx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_encryptor.sv
// Randomized scoreboard bench for stream_encryptor.
// Model keys off message byte count; kidx is derived as pos mod SEC_LEN.
module tb_stream_encryptor;

  localparam int MSG_LEN = 20;
  localparam int SEC_LEN = 3;

`ifdef ENCRYPTOR_DEFAULT_KEY_EN
  localparam logic [23:0] RST_KEY = "KEY";
`else
  localparam logic [23:0] RST_KEY = 24'h0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       key_we;
  logic [1:0] key_idx;
  logic [7:0] key_byte;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;
  int cyc     = 0;

  logic [8:0] q[$];
  logic [7:0] mkey [SEC_LEN];
  int         mpos;
  logic       prev_acc;
  logic       stall_prev;
  logic [8:0] held;

  stream_encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
    .clk(clk), .rst(rst),
    .key_we(key_we), .key_idx(key_idx), .key_byte(key_byte),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    mpos = 0;
    prev_acc = 1'b0;
    for (int i = 0; i < SEC_LEN; i++)
      mkey[i] = RST_KEY[8*(2-(i%3)) +: 8];
  endfunction

  // Reference model: sees each handshake just before the edge that commits it.
  always @(negedge clk) begin
    logic       acc;
    logic [7:0] e;
    if (rst) begin
      model_reset();
    end else begin
      if (prev_acc) chk("latency", out_valid, 1);
      chk("busy", busy, (mpos != 0));
      acc = in_valid && in_ready;
      if (acc) begin
        e = in_data + mkey[mpos % SEC_LEN];
        q.push_back({(mpos == MSG_LEN - 1), e});
        mpos = (mpos + 1) % MSG_LEN;
      end else if (key_we && mpos == 0 && int'(key_idx) < SEC_LEN) begin
        mkey[key_idx] = key_byte;
      end
      prev_acc = acc;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_out", {out_last, out_data}, held);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_output", {out_last, out_data}, 9'h1ff);
        end else begin
          exp = q.pop_front();
          chk("out_data", out_data, exp[7:0]);
          chk("out_last", out_last, exp[8]);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_last, out_data};
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    case (mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = !(cyc >= 5 && cyc <= 8);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    key_we = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_key(input logic [1:0] idx, input logic [7:0] b);
    key_we = 1'b1;
    key_idx = idx;
    key_byte = b;
    tick();
    key_we = 1'b0;
  endtask

  task automatic write_kw();
    write_key(2'd0, "K");
    write_key(2'd1, "E");
    write_key(2'd2, "Y");
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      tick();
    end
    if (!got) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (out_valid || q.size() != 0); i++) tick();
    chk("drain_q", q.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    key_we = 1'b0;
    key_idx = '0;
    key_byte = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // "ABC" with key "KEY" at full rate
    write_kw();
    send_byte("A");
    chk("abc_0", out_data, 140);
    send_byte("B");
    chk("abc_1", out_data, 135);
    send_byte("C");
    chk("abc_2", out_data, 156);
    chk("abc_busy", busy, 1);

    // reset mid-message, then wrap case
    do_reset();
    chk("rst2_valid", out_valid, 0);
    chk("rst2_busy", busy, 0);
    write_kw();
    send_byte(8'hF0);
    chk("wrap", out_data, 8'h3B);
    send_rand(MSG_LEN - 1);
    drain();

    // back-pressure window on a full message
    do_reset();
    write_kw();
    mode = 2;
    cyc = 0;
    send_rand(MSG_LEN);
    drain();
    chk("stall_busy", busy, 0);
    mode = 0;

    // key writes during RUN, out of range, and colliding with an accept
    send_rand(5);
    key_we = 1'b1;
    key_idx = 2'd0;
    key_byte = 8'h01;
    send_byte(8'h10);
    tick();
    key_we = 1'b0;
    send_rand(MSG_LEN - 6);
    drain();
    write_key(2'd0, 8'h01);
    write_key(2'd3, 8'hAA);
    key_we = 1'b1;
    key_idx = 2'd1;
    key_byte = 8'h77;
    b = 8'($urandom);
    send_byte(b);
    key_we = 1'b0;
    chk("idle_key_wr", out_data, 8'(b + 8'h01));
    b = 8'($urandom);
    send_byte(b);
    chk("collide_old_key", out_data, 8'(b + "E"));
    send_rand(MSG_LEN - 2);
    drain();

    // reset after byte 7
    send_rand(7);
    do_reset();
    chk("rst7_valid", out_valid, 0);
    chk("rst7_busy", busy, 0);
    b = 8'($urandom);
    send_byte(b);
    chk("rst7_key0", out_data, 8'(b + RST_KEY[23:16]));
    send_rand(MSG_LEN - 1);
    drain();

    // two back-to-back messages, then random traffic with back-pressure
    for (int i = 0; i < SEC_LEN; i++) write_key(2'(i), 8'($urandom));
    send_rand(2 * MSG_LEN);
    drain();
    mode = 1;
    for (int i = 0; i < 3 * MSG_LEN; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        key_we = 1'b1;
        key_idx = 2'($urandom);
        key_byte = 8'($urandom);
        tick();
        key_we = 1'b0;
      end
      send_byte(8'($urandom));
    end
    drain();
    chk("end_busy", busy, 0);
    mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
